// File: rtl/thermostat_packet_tx.sv
// Thermostat packet transmitter.
// Captures the packet fields on an accepted start and sends the 192-bit frame
// MSB first as a Manchester-encoded line. A 1 is sent as high then low, and a
// 0 is sent as low then high. After the last bit the line stays low for a
// fixed gap, and then done pulses for one cycle.
module thermostat_packet_tx #(
    parameter int          HALF_BIT_CYCLES = 4,
    parameter int          GAP_CYCLES      = 16,
    parameter logic [31:0] PREAMBLE        = 32'hAAAAAAAA,
    parameter logic [15:0] TYPE_WORD       = 16'hD391,
    parameter logic [31:0] CONSTANT        = 32'h0DFFFFFE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        tx_out,
    output logic        busy,
    output logic        done
);

    localparam int HW = $clog2(HALF_BIT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
    // When there is no gap, the gap terminal value is never used. It is kept
    // at zero so that the localparam stays legal.
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]    BIT_LAST  = 8'd191;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [191:0]   shift_q, shift_d;
    logic [HW-1:0]  half_q, half_d;
    logic           phase_q, phase_d;
    logic [7:0]     bit_q, bit_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [191:0]   frame_w;

    assign frame_w = {PREAMBLE, TYPE_WORD, thermostat_id, TYPE_WORD, CONSTANT,
                      room_temp, set_temp, state, tail_1, tail_2, tail_3};

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // State and datapath registers. Reset aborts any frame in progress at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            shift_q <= '0;
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            shift_q <= shift_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. The line level for the next cycle is computed here,
    // so the output register changes on the same edge as the half-bit
    // boundary. This leaves no bubble between bits.
    always_comb begin
        fsm_d   = fsm_q;
        shift_d = shift_q;
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                tx_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    fsm_d   = S_SEND;
                    shift_d = frame_w;
                    half_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    tx_d    = frame_w[191];
                    busy_d  = 1'b1;
                end
            end

            S_SEND: begin
                busy_d = 1'b1;
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (!phase_q) begin
                        // Mid-bit transition: send the inverse half.
                        phase_d = 1'b1;
                        tx_d    = ~shift_q[191];
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            tx_d  = 1'b0;
                            gap_d = '0;
                            if (GAP_CYCLES == 0) begin
                                fsm_d  = S_DONE;
                                busy_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                fsm_d = S_GAP;
                            end
                        end else begin
                            shift_d = {shift_q[190:0], 1'b0};
                            bit_d   = bit_q + 8'd1;
                            tx_d    = shift_q[190];
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            S_GAP: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    fsm_d  = S_DONE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            S_DONE: begin
                // Start is ignored here. Back-to-back frames restart only
                // from IDLE on the following cycle.
                fsm_d  = S_IDLE;
                tx_d   = 1'b0;
                busy_d = 1'b0;
            end

            default: begin
                fsm_d  = S_IDLE;
                tx_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_thermostat_packet_tx.sv
// Directed bench for thermostat_packet_tx. It uses two instances: a slow
// line (2 cycles per half-bit with a 4-cycle gap) and a full-rate line
// (1 cycle per half-bit with no gap).
module tb_thermostat_packet_tx;

    localparam int HA = 2;
    localparam int GA = 4;
    localparam int HB = 1;
    localparam int GB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic [31:0] id;
    logic [15:0] room, setp;
    logic [7:0]  st, t1, t2, t3;
    logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    thermostat_packet_tx #(.HALF_BIT_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clock(clk), .reset(rst_a), .start(start_a),
        .thermostat_id(id), .room_temp(room), .set_temp(setp), .state(st),
        .tail_1(t1), .tail_2(t2), .tail_3(t3),
        .tx_out(tx_a), .busy(busy_a), .done(done_a)
    );

    thermostat_packet_tx #(.HALF_BIT_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clock(clk), .reset(rst_b), .start(start_b),
        .thermostat_id(id), .room_temp(room), .set_temp(setp), .state(st),
        .tail_1(t1), .tail_2(t2), .tail_3(t3),
        .tx_out(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected frame: the fixed words plus the fields, MSB first.
    function automatic logic [191:0] frame();
        return {32'hAAAAAAAA, 16'hD391, id, 16'hD391, 32'h0DFFFFFE,
                room, setp, st, t1, t2, t3};
    endfunction

    // Called at sample time of the first busy cycle (c=0). Observes up to the
    // IDLE cycle after DONE and returns at c = n + gap + 2. Asserts start_a
    // (DUT a only) at sample points p1 and p2.
    task automatic watch(input int which, input int hb, input int gap,
                         input logic [191:0] exp, input int p1, input int p2,
                         output int tx_err, output int busy_len,
                         output int done_at, output int done_cnt,
                         output logic [15:0] first16, output logic [191:0] dec);
        int n;
        n = 384 * hb;
        tx_err = 0; busy_len = 0; done_at = -1; done_cnt = 0;
        first16 = '0; dec = '0;
        for (int c = 0; c <= n + gap + 1; c++) begin
            logic t, b, d, e, ph;
            int   bi;
            t = (which != 0) ? tx_b   : tx_a;
            b = (which != 0) ? busy_b : busy_a;
            d = (which != 0) ? done_b : done_a;
            if (which == 0) start_a = (c == p1) || (c == p2);
            if (c < n) begin
                bi = 191 - c / (2 * hb);
                ph = ((c / hb) % 2) == 1;
                e  = exp[bi] ^ ph;
                if (t !== e) tx_err++;
                if (!ph && (c % hb) == 0) dec[bi] = t;
            end else if (t !== 1'b0) begin
                tx_err++;
            end
            if (c < 16) first16[15 - c] = t;
            if (b === 1'b1) busy_len++;
            if (d === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            tick();
        end
        if (which == 0) start_a = 1'b0;
    endtask

    initial begin
        int           tx_err, busy_len, done_at, done_cnt, acc;
        logic [15:0]  first16;
        logic [191:0] dec, exp1, exp3;

        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        id = 32'h12345678; room = 16'h00D2; setp = 16'h00C8; st = 8'h05;
        t1 = 8'hA1; t2 = 8'hB2; t3 = 8'hC3;

        // Reset state, with start high while reset is held.
        #1 rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b1;
        #2;
        chk("rst_tx",   tx_a,   1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy_a !== 1'b0 || tx_a !== 1'b0) acc++;
        end
        chk("rst_hold_idle", acc, 0);
        start_a = 1'b0;
        rst_a = 1'b0;
        tick(); tick();

        // Frame 1: loopback fields. The fields change after accept. Start is
        // pulsed again mid-frame and during DONE.
        exp1 = frame();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        id = 32'hFFFFFFFF; room = 16'h1111; setp = 16'h2222; st = 8'h33;
        watch(0, HA, GA, exp1, 50, 384 * HA + GA, tx_err, busy_len, done_at, done_cnt, first16, dec);
        chk("f1_first16",  first16, 16'hC3C3);
        chk("f1_tx_err",   tx_err, 0);
        chk("f1_frame",    dec, exp1);
        chk("f1_room",     dec[63:48], 16'h00D2);
        chk("f1_set",      dec[47:32], 16'h00C8);
        chk("f1_tails",    dec[23:0], 24'hA1B2C3);
        chk("f1_busy_len", busy_len, 772);
        chk("f1_done_at",  done_at, 772);
        chk("f1_done_cnt", done_cnt, 1);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy_a !== 1'b0 || done_a !== 1'b0) acc++;
            tick();
        end
        chk("f1_no_queue", acc, 0);

        // Frame 2: reset in the first half of bit 100.
        id = 32'hCAFEF00D; room = 16'h00F0; setp = 16'h0101; st = 8'h7E;
        t1 = 8'h01; t2 = 8'h80; t3 = 8'hFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (400) tick();
        chk("f2_busy_before", busy_a, 1'b1);
        rst_a = 1'b1;
        #1;
        chk("f2_abort_tx",   tx_a,   1'b0);
        chk("f2_abort_busy", busy_a, 1'b0);
        chk("f2_abort_done", done_a, 1'b0);
        start_a = 1'b1;
        repeat (3) tick();
        chk("f2_hold_busy", busy_a, 1'b0);
        start_a = 1'b0;
        rst_a = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy_a !== 1'b0 || done_a !== 1'b0 || tx_a !== 1'b0) acc++;
        end
        chk("f2_quiet_after", acc, 0);

        // Frame 3: fresh complete frame after the abort.
        exp3 = frame();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        watch(0, HA, GA, exp3, -1, -1, tx_err, busy_len, done_at, done_cnt, first16, dec);
        chk("f3_first16",  first16, 16'hC3C3);
        chk("f3_tx_err",   tx_err, 0);
        chk("f3_frame",    dec, exp3);
        chk("f3_busy_len", busy_len, 772);
        chk("f3_done_at",  done_at, 772);
        chk("f3_done_cnt", done_cnt, 1);

        // Full rate with no gap: start held high gives back-to-back frames.
        rst_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("b%0d_busy_rise", f), busy_b, 1'b1);
            watch(1, HB, GB, exp3, -1, -1, tx_err, busy_len, done_at, done_cnt, first16, dec);
            chk($sformatf("b%0d_tx_err", f),   tx_err, 0);
            chk($sformatf("b%0d_frame", f),    dec, exp3);
            chk($sformatf("b%0d_busy_len", f), busy_len, 384);
            chk($sformatf("b%0d_done_at", f),  done_at, 384);
            chk($sformatf("b%0d_done_cnt", f), done_cnt, 1);
        end
        start_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
